// File: rtl/complex_mult_pkg.sv
// Shared helpers for complex_mult: component split of {im, re} words and
// the output slice MSB index.
package complex_mult_pkg;

   // Highest full-product bit kept in each output component.
   function automatic int slice_msb(input int a_w, input int b_w, input int growth);
      return a_w + b_w - 2 + growth;
   endfunction

   // Real part: low w bits, sign-extended to 32 bits.
   function automatic logic [31:0] comp_re(input logic [63:0] d, input int unsigned w);
      logic [31:0] r;
      for (int unsigned i = 0; i < 32; i++)
         r[i] = (i < w) ? d[i] : d[w-1];
      return r;
   endfunction

   // Imaginary part: bits [2w-1:w], sign-extended to 32 bits.
   function automatic logic [31:0] comp_im(input logic [63:0] d, input int unsigned w);
      logic [31:0] r;
      for (int unsigned i = 0; i < 32; i++)
         r[i] = (i < w) ? d[w+i] : d[2*w-1];
      return r;
   endfunction

endpackage

// File: rtl/complex_mult_valid_delay_line.sv
// Shift register carrying tvalid alongside the arithmetic pipeline; every
// stage is exposed so each data stage can load only when its slot is valid.
module valid_delay_line #(
   parameter int DEPTH = 6
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_din,
   output logic [DEPTH-1:0] o_taps
);

   logic [DEPTH-1:0] r_sh;

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) r_sh <= '0;
      else          r_sh <= {r_sh[DEPTH-2:0], i_din};
   end

   assign o_taps = r_sh;

endmodule

// File: rtl/complex_mult.sv
// Pipelined complex multiplier, fixed latency STAGES, no backpressure.
// Define COMPLEX_MULT_SAT_EN to saturate output components instead of wrapping.
module complex_mult
   import complex_mult_pkg::*;
#(
   parameter int OPERAND_WIDTH_A   = 16,
   parameter int OPERAND_WIDTH_B   = 16,
   parameter int OPERAND_WIDTH_OUT = 16,
   parameter int STAGES            = 6,
   parameter int BLOCKING          = 0,
   parameter int GROWTH_BITS       = 0
) (
   input  logic                             aclk,
   input  logic                             aresetn,
   input  logic [2*OPERAND_WIDTH_A-1:0]     s_axis_a_tdata,
   input  logic                             s_axis_a_tvalid,
   input  logic [2*OPERAND_WIDTH_B-1:0]     s_axis_b_tdata,
   input  logic                             s_axis_b_tvalid,
   output logic [2*OPERAND_WIDTH_OUT-1:0]   m_axis_dout_tdata,
   output logic                             m_axis_dout_tvalid
);

   localparam int AW   = OPERAND_WIDTH_A;
   localparam int BW   = OPERAND_WIDTH_B;
   localparam int OW   = OPERAND_WIDTH_OUT;
   localparam int PW   = AW + BW;
   localparam int W    = PW + 1;
   localparam int MSB  = slice_msb(AW, BW, GROWTH_BITS);
   localparam int LSB  = MSB - OW + 1;
   localparam int RSH  = (LSB > 0) ? LSB : 0;
   localparam int LSH  = (LSB < 0) ? -LSB : 0;
   localparam int XW   = W + 2*OW;
   localparam int unsigned NDLY = STAGES - 2;

   logic [2*AW-1:0]   w_a_dat;
   logic [2*BW-1:0]   w_b_dat;
   logic              w_accept;
   logic [STAGES-1:0] w_vtap;

   generate
      if (BLOCKING != 0) begin : g_blk
         logic [2*AW-1:0] r_hold_a;
         logic [2*BW-1:0] r_hold_b;
         logic            r_hold_a_v;
         logic            r_hold_b_v;

         always_ff @(posedge aclk) begin
            if (!aresetn) begin
               r_hold_a   <= '0;
               r_hold_b   <= '0;
               r_hold_a_v <= 1'b0;
               r_hold_b_v <= 1'b0;
            end else if (w_accept) begin
               r_hold_a_v <= 1'b0;
               r_hold_b_v <= 1'b0;
            end else begin
               if (s_axis_a_tvalid) begin
                  r_hold_a   <= s_axis_a_tdata;
                  r_hold_a_v <= 1'b1;
               end
               if (s_axis_b_tvalid) begin
                  r_hold_b   <= s_axis_b_tdata;
                  r_hold_b_v <= 1'b1;
               end
            end
         end

         // A beat on the port supersedes whatever is being held.
         assign w_a_dat  = s_axis_a_tvalid ? s_axis_a_tdata : r_hold_a;
         assign w_b_dat  = s_axis_b_tvalid ? s_axis_b_tdata : r_hold_b;
         assign w_accept = (s_axis_a_tvalid | r_hold_a_v) & (s_axis_b_tvalid | r_hold_b_v);
      end else begin : g_nblk
         assign w_a_dat  = s_axis_a_tdata;
         assign w_b_dat  = s_axis_b_tdata;
         assign w_accept = s_axis_a_tvalid & s_axis_b_tvalid;
      end
   endgenerate

   valid_delay_line #(.DEPTH(STAGES)) u_vdl (
      .i_clk   (aclk),
      .i_rst_n (aresetn),
      .i_din   (w_accept),
      .o_taps  (w_vtap)
   );

   function automatic logic [OW-1:0] f_scale(input logic signed [W-1:0] full);
      logic signed [XW-1:0] x;
      x = (XW'(full) <<< LSH) >>> RSH;
`ifdef COMPLEX_MULT_SAT_EN
      if ((x[XW-1:OW-1] == '0) || (x[XW-1:OW-1] == '1))
         return x[OW-1:0];
      else
         return x[XW-1] ? {1'b1, {(OW-1){1'b0}}} : {1'b0, {(OW-1){1'b1}}};
`else
      return x[OW-1:0];
`endif
   endfunction

   logic signed [AW-1:0] r_ar, r_ai;
   logic signed [BW-1:0] r_br, r_bi;
   logic signed [PW-1:0] r_p_rr, r_p_ii, r_p_ri, r_p_ir;
   logic signed [W-1:0]  w_re_full, w_im_full;
   logic [2*OW-1:0]      r_dat [NDLY];

   assign w_re_full = W'(r_p_rr) - W'(r_p_ii);
   assign w_im_full = W'(r_p_ri) + W'(r_p_ir);

   // Each stage loads only when its slot holds a valid pair, so the output
   // register keeps its last value between results.
   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         r_ar   <= '0;
         r_ai   <= '0;
         r_br   <= '0;
         r_bi   <= '0;
         r_p_rr <= '0;
         r_p_ii <= '0;
         r_p_ri <= '0;
         r_p_ir <= '0;
         for (int unsigned j = 0; j < NDLY; j++) r_dat[j] <= '0;
      end else begin
         if (w_accept) begin
            r_ar <= AW'(comp_re(64'(w_a_dat), AW));
            r_ai <= AW'(comp_im(64'(w_a_dat), AW));
            r_br <= BW'(comp_re(64'(w_b_dat), BW));
            r_bi <= BW'(comp_im(64'(w_b_dat), BW));
         end
         if (w_vtap[0]) begin
            r_p_rr <= PW'(r_ar) * PW'(r_br);
            r_p_ii <= PW'(r_ai) * PW'(r_bi);
            r_p_ri <= PW'(r_ar) * PW'(r_bi);
            r_p_ir <= PW'(r_ai) * PW'(r_br);
         end
         if (w_vtap[1]) r_dat[0] <= {f_scale(w_im_full), f_scale(w_re_full)};
         for (int unsigned j = 1; j < NDLY; j++)
            if (w_vtap[j+1]) r_dat[j] <= r_dat[j-1];
      end
   end

   assign m_axis_dout_tdata  = r_dat[NDLY-1];
   assign m_axis_dout_tvalid = w_vtap[STAGES-1];

endmodule

// File: tb/tb_complex_mult.sv
// Scoreboard bench for complex_mult: three DUTs (wrap/growth 0, growth -1,
// blocking) share one randomized stimulus stream against an integer model.
module tb_complex_mult;

   localparam int AW = 8;
   localparam int BW = 8;
   localparam int OW = 8;
   localparam int ST = 6;

   typedef struct {
      logic [15:0] d;
      int          c;
   } exp_t;

   logic        clk = 1'b0;
   logic        rstn = 1'b0;
   logic [15:0] a_d = '0;
   logic [15:0] b_d = '0;
   logic        a_v = 1'b0;
   logic        b_v = 1'b0;
   logic [15:0] od [3];
   logic        ov [3];

   int   cyc = 0;
   int   vec = 0;
   int   miss = 0;
   exp_t q [3][$];

   logic [15:0] pa, pb;
   bit          pa_v = 0, pb_v = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   complex_mult #(.OPERAND_WIDTH_A(AW), .OPERAND_WIDTH_B(BW), .OPERAND_WIDTH_OUT(OW),
                  .STAGES(ST), .BLOCKING(0), .GROWTH_BITS(0)) u_g0 (
      .aclk(clk), .aresetn(rstn),
      .s_axis_a_tdata(a_d), .s_axis_a_tvalid(a_v),
      .s_axis_b_tdata(b_d), .s_axis_b_tvalid(b_v),
      .m_axis_dout_tdata(od[0]), .m_axis_dout_tvalid(ov[0]));

   complex_mult #(.OPERAND_WIDTH_A(AW), .OPERAND_WIDTH_B(BW), .OPERAND_WIDTH_OUT(OW),
                  .STAGES(ST), .BLOCKING(0), .GROWTH_BITS(-1)) u_gm1 (
      .aclk(clk), .aresetn(rstn),
      .s_axis_a_tdata(a_d), .s_axis_a_tvalid(a_v),
      .s_axis_b_tdata(b_d), .s_axis_b_tvalid(b_v),
      .m_axis_dout_tdata(od[1]), .m_axis_dout_tvalid(ov[1]));

   complex_mult #(.OPERAND_WIDTH_A(AW), .OPERAND_WIDTH_B(BW), .OPERAND_WIDTH_OUT(OW),
                  .STAGES(ST), .BLOCKING(1), .GROWTH_BITS(0)) u_blk (
      .aclk(clk), .aresetn(rstn),
      .s_axis_a_tdata(a_d), .s_axis_a_tvalid(a_v),
      .s_axis_b_tdata(b_d), .s_axis_b_tvalid(b_v),
      .m_axis_dout_tdata(od[2]), .m_axis_dout_tvalid(ov[2]));

   // Floor-scale a full product and fit it into OW bits.
   function automatic longint fit(input longint full, input int g);
      int     lsb;
      longint v;
      lsb = AW + BW - 1 + g - OW;
      v   = full >>> lsb;
`ifdef COMPLEX_MULT_SAT_EN
      if (v > 127)  v = 127;
      if (v < -128) v = -128;
`else
      v = ((v % 256) + 256) % 256;
      if (v >= 128) v = v - 256;
`endif
      return v;
   endfunction

   function automatic logic [15:0] cmul(input logic [15:0] a, input logic [15:0] b, input int g);
      longint ar, ai, br, bi, re, im;
      ar = longint'($signed(a[7:0]));
      ai = longint'($signed(a[15:8]));
      br = longint'($signed(b[7:0]));
      bi = longint'($signed(b[15:8]));
      re = fit(ar*br - ai*bi, g);
      im = fit(ar*bi + ai*br, g);
      return {im[7:0], re[7:0]};
   endfunction

   task automatic drive(input bit av, input bit bv, input logic [15:0] a, input logic [15:0] b);
      a_v = av; b_v = bv; a_d = a; b_d = b;
      if (av && bv) begin
         q[0].push_back('{cmul(a, b, 0),  cyc + ST});
         q[1].push_back('{cmul(a, b, -1), cyc + ST});
      end
      if (av) begin pa = a; pa_v = 1; end
      if (bv) begin pb = b; pb_v = 1; end
      if (pa_v && pb_v) begin
         q[2].push_back('{cmul(pa, pb, 0), cyc + ST});
         pa_v = 0; pb_v = 0;
      end
      @(posedge clk); #1;
   endtask

   // Drop expectations that the reset edge will destroy.
   task automatic purge();
      for (int k = 0; k < 3; k++)
         while (q[k].size() > 0 && q[k][$].c > cyc) void'(q[k].pop_back());
      pa_v = 0; pb_v = 0;
   endtask

   task automatic do_reset(input int n);
      rstn = 1'b0; a_v = 1'b0; b_v = 1'b0;
      purge();
      repeat (n) begin @(posedge clk); #1; end
      for (int k = 0; k < 3; k++) begin
         vec++;
         if (ov[k] !== 1'b0 || od[k] !== 16'h0000) begin
            miss++;
            $display("FAIL reset_state dut%0d: tvalid=%b tdata=%h, expected tvalid=0 tdata=0000", k, ov[k], od[k]);
         end
      end
      rstn = 1'b1;
   endtask

   always @(negedge clk) begin : mon
      exp_t e;
      for (int k = 0; k < 3; k++) begin
         if (q[k].size() > 0 && q[k][0].c < cyc) begin
            e = q[k].pop_front();
            miss++;
            $display("FAIL missing_result dut%0d: no tvalid at cycle %0d, expected data %h", k, e.c, e.d);
         end
         if (ov[k] === 1'b1) begin
            vec++;
            if (q[k].size() == 0) begin
               miss++;
               $display("FAIL unexpected_valid dut%0d: tvalid data %h at cycle %0d, expected none", k, od[k], cyc);
            end else begin
               e = q[k].pop_front();
               if (od[k] !== e.d || cyc != e.c) begin
                  miss++;
                  $display("FAIL result dut%0d: got %h at cycle %0d, expected %h at cycle %0d", k, od[k], cyc, e.d, e.c);
               end
            end
         end
      end
   end

   initial begin
      do_reset(3);

      // Directed corner products.
      drive(1, 1, {8'd0, 8'd64},    {8'd0, 8'd127});
      drive(1, 1, {8'd64, 8'd0},    {8'd127, 8'd0});
      drive(1, 1, {8'd0, 8'd32},    {8'd0, 8'd127});
      drive(1, 1, {8'd0, 8'h80},    {8'd0, 8'h80});
      drive(1, 1, {8'h80, 8'h80},   {8'h80, 8'h80});
      drive(1, 1, {8'h7f, 8'h81},   {8'h81, 8'h7f});
      repeat (3) drive(0, 0, '0, '0);

      // Back-to-back ramp.
      for (int k = 0; k < 10; k++) drive(1, 1, {8'd0, 8'(k)}, {8'd0, 8'd127});
      repeat (2) drive(0, 0, '0, '0);

      // Random operands and valid patterns.
      for (int i = 0; i < 400; i++)
         drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
               16'($urandom()), 16'($urandom()));
      repeat (ST + 2) drive(0, 0, '0, '0);

      // Reset one cycle after three accepted pairs.
      for (int k = 1; k <= 3; k++) drive(1, 1, {8'd5, 8'(k)}, {8'd3, 8'd100});
      rstn = 1'b0; a_v = 1'b0; b_v = 1'b0;
      purge();
      @(posedge clk); #1;
      rstn = 1'b1;
      repeat (ST + 2) drive(0, 0, '0, '0);
      drive(1, 1, {8'd10, 8'd20}, {8'hf0, 8'd50});
      repeat (ST + 2) drive(0, 0, '0, '0);

      // Split arrival: only the blocking DUT pairs them.
      do_reset(1);
      drive(1, 0, {8'd7, 8'd40}, '0);
      drive(0, 0, '0, '0);
      drive(0, 0, '0, '0);
      drive(0, 1, '0, {8'd9, 8'd90});
      repeat (ST + 4) drive(0, 0, '0, '0);

      for (int i = 0; i < 50; i++) begin
         if (q[0].size() == 0 && q[1].size() == 0 && q[2].size() == 0) break;
         @(posedge clk); #1;
      end
      for (int k = 0; k < 3; k++) begin
         if (q[k].size() != 0) begin
            miss++;
            $display("FAIL drain_timeout dut%0d: %0d results outstanding, expected 0", k, q[k].size());
         end
      end
      @(negedge clk); #1;
      $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
      $finish;
   end

endmodule

// File: doc/complex_mult.md
COMPLEX_MULT -- requirements
Module: complex_mult

Interface
REQ-001 Parameter OPERAND_WIDTH_A, default 16: bit width of each component (re, im) of operand A.
REQ-002 Parameter OPERAND_WIDTH_B, default 16: bit width of each component of operand B.
REQ-003 Parameter OPERAND_WIDTH_OUT, default 16: bit width of each output component.
REQ-004 Parameter STAGES, default 6, legal range 3..16: input-to-output latency in cycles.
REQ-005 Parameter BLOCKING, default 0: 1 selects the operand-pairing mode defined in REQ-016.
REQ-006 Parameter GROWTH_BITS, default 0, signed, range -(OPERAND_WIDTH_OUT-1)..1: output scaling (REQ-012).
REQ-007 Clocking and reset: one clock; reset is synchronous and active-low.
REQ-008 aclk  in  1  clock; all logic on the rising edge.
REQ-009 aresetn  in  1  synchronous active-low reset.
REQ-010 s_axis_a_tdata  in  2*OPERAND_WIDTH_A  {im, re}, two's complement; s_axis_a_tvalid  in  1  A valid.
REQ-011 s_axis_b_tdata  in  2*OPERAND_WIDTH_B  {im, re}; s_axis_b_tvalid  in  1  B valid; m_axis_dout_tdata  out  2*OPERAND_WIDTH_OUT  {im, re}; m_axis_dout_tvalid  out  1.

Function
REQ-012 Full products are exact at width W = A+B+1: re = ar*br - ai*bi, im = ar*bi + ai*br; each output component is bits [A+B-2+GROWTH_BITS -: OUT] of the corresponding full product (truncation toward minus infinity), with sign extension where the index exceeds W-1.
REQ-013 With GROWTH_BITS=0, a full-scale coefficient (2^(B-1)-1) multiplies operand A by 1 minus 1 LSB; each -1 step of GROWTH_BITS doubles the gain.
REQ-014 Without the REQ-022 macro, bits discarded above the MSB are dropped (two's-complement wrap).
REQ-015 BLOCKING=0: the operands are sampled every cycle; a pair is accepted in cycle n when a_tvalid and b_tvalid are both high, and its result appears in cycle n+STAGES with dout_tvalid=1.
REQ-016 BLOCKING=1: each operand is held in a one-entry register until its partner arrives; a pair is accepted in the cycle where both are present (held or on-port). A new valid beat on an operand already holding a value overwrites the held value.
REQ-017 dout_tvalid is high exactly one cycle per accepted pair; it is low in all other cycles; no backpressure (no tready).
REQ-018 Back-to-back pairs sustain throughput 1 result/cycle with fixed latency STAGES; results are in order.
REQ-019 m_axis_dout_tdata is undefined-but-stable (holds its last value) when tvalid=0.

Reset
REQ-020 While aresetn=0 at a rising edge: dout_tvalid=0, dout_tdata=0, all pipeline valid bits and BLOCKING holding registers are cleared.
REQ-021 Reset mid-operation discards all in-flight pairs; no tvalid is produced for pairs accepted before reset; the first pair after reset release has full latency STAGES.

Configuration
REQ-022 Macro COMPLEX_MULT_SAT_EN: when defined, each output component saturates to +(2^(OUT-1)-1) / -2^(OUT-1) whenever discarded upper bits are not a sign extension; when undefined, REQ-014 wrap applies. Latency is unchanged in both cases.

Structure
REQ-023 Package complex_mult_pkg holds the component-split helpers (re/im slice functions) and the MSB-index computation constant used in REQ-012.
REQ-024 One sub-module, valid_delay_line (parameterized depth, synchronous clear), carries tvalid alongside the arithmetic pipeline; the arithmetic is inline: input register, products, sum/difference, scale/saturate, remaining delay.

Verification (A=B=OUT=8, GROWTH_BITS=0, STAGES=6 unless stated)
REQ-025 a=(re 64, im 0), b=(127, 0), both valid cycle n -> cycle n+6: re=63, im=0, tvalid=1 for one cycle.
REQ-026 a=(0, 64), b=(0, 127) -> re=-64 (floor of -63.5), im=0; GROWTH_BITS=-1 with a=(32,0), b=(127,0) -> re=63.
REQ-027 a=(-128,0), b=(-128,0) -> re=-128 without COMPLEX_MULT_SAT_EN, re=127 with it.
REQ-028 Ten consecutive valid pairs with a=(k,0), b=(127,0), k=0..9 -> ten consecutive tvalid cycles with re=floor(127k/128), in order.
REQ-029 BLOCKING=1: A valid cycle 0 only, B valid cycle 3 only -> exactly one result at cycle 3+STAGES; BLOCKING=0 with the same stimulus -> no output.
REQ-030 Reset asserted one cycle after accepting 3 pairs -> tvalid stays 0 for the following STAGES+2 cycles, then a fresh pair yields a result with exact latency 6.
